// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer: sequences one PID iteration per pid_tick
// (sample -> compute -> commit) and commits the new duty to the PWM
// only on a pwm_tick period boundary. Counts dropped ticks (overruns).
// Optional handshake watchdog built when SEQ_TIMEOUT_EN is defined;
// otherwise timeout_err is tied to 0 and the FSM waits indefinitely.
module pid_loop_sequencer #(
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       DUTY_W     = 12,
    parameter logic [DUTY_W-1:0] DUTY_RESET = 12'hFFF,
    parameter logic [15:0]       TIMEOUT    = 16'd50000
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              pid_tick,
    input  logic              pwm_tick,
    output logic              sample_req,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              pid_start,
    output logic [DATA_W-1:0] pid_in,
    input  logic              pid_done,
    input  logic [DUTY_W-1:0] pid_duty,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic [7:0]        overrun_cnt,
    output logic              timeout_err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        COMPUTE = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sample_req_q, sample_req_d;
    logic                pid_start_q, pid_start_d;
    logic [DATA_W-1:0]   pid_in_q, pid_in_d;
    logic [DUTY_W-1:0]   pending_q, pending_d;
    logic [DUTY_W-1:0]   duty_out_q, duty_out_d;
    logic                busy_q, busy_d;
    logic [7:0]          overrun_cnt_q, overrun_cnt_d;
    logic                overrun;
    logic                wdog_expire;

`ifdef SEQ_TIMEOUT_EN
    logic [15:0]         wdog_q, wdog_d;
    logic                timeout_err_q, timeout_err_d;
    logic                timeout_set;

    // Watchdog: restarts on entry to a waiting state, counts while waiting
    always_comb begin
        wdog_d      = wdog_q;
        wdog_expire = (wdog_q == 16'(TIMEOUT - 16'd1));
        // A strobe in the expiry cycle takes precedence over the timeout
        timeout_set = wdog_expire &&
                      ((state_q == SAMPLE  && !sample_valid) ||
                       (state_q == COMPUTE && !pid_done));
        if ((state_d == SAMPLE  && state_q != SAMPLE) ||
            (state_d == COMPUTE && state_q != COMPUTE)) begin
            wdog_d = '0;
        end else if (state_q == SAMPLE || state_q == COMPUTE) begin
            wdog_d = wdog_q + 16'd1;
        end
        // New timeout beats a simultaneous clear
        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // Watchdog and sticky timeout flag registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wdog_expire = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state, handshake outputs, data latches and overrun counter
    always_comb begin
        state_d      = state_q;
        sample_req_d = 1'b0;
        pid_start_d  = 1'b0;
        pid_in_d     = pid_in_q;
        pending_d    = pending_q;
        duty_out_d   = duty_out_q;

        case (state_q)
            IDLE: begin
                if (pid_tick) begin
                    sample_req_d = 1'b1;
                    state_d      = SAMPLE;
                end
            end
            SAMPLE: begin
                if (sample_valid) begin
                    pid_in_d    = sample_data;
                    pid_start_d = 1'b1;
                    state_d     = COMPUTE;
                end else if (wdog_expire) begin
                    state_d = IDLE;
                end
            end
            COMPUTE: begin
                if (pid_done) begin
                    pending_d = pid_duty;
                    state_d   = COMMIT;
                end else if (wdog_expire) begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                if (pwm_tick) begin
                    duty_out_d = pending_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        // A tick outside IDLE is dropped; a new overrun beats a simultaneous clear
        overrun = pid_tick && (state_q != IDLE);
        if (err_clr) begin
            overrun_cnt_d = overrun ? 8'd1 : 8'd0;
        end else if (overrun && overrun_cnt_q != 8'hFF) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end else begin
            overrun_cnt_d = overrun_cnt_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sample_req_q  <= 1'b0;
            pid_start_q   <= 1'b0;
            pid_in_q      <= '0;
            pending_q     <= '0;
            duty_out_q    <= DUTY_RESET;
            busy_q        <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            sample_req_q  <= sample_req_d;
            pid_start_q   <= pid_start_d;
            pid_in_q      <= pid_in_d;
            pending_q     <= pending_d;
            duty_out_q    <= duty_out_d;
            busy_q        <= busy_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign sample_req  = sample_req_q;
    assign pid_start   = pid_start_q;
    assign pid_in      = pid_in_q;
    assign duty_out    = duty_out_q;
    assign busy        = busy_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed testbench for pid_loop_sequencer. The timeout scenario is
// exercised against the watchdog when SEQ_TIMEOUT_EN is defined, and
// checks the indefinite wait otherwise.
module tb_pid_loop_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        pid_tick = 1'b0;
    logic        pwm_tick = 1'b0;
    logic        sample_req;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        pid_start;
    logic [15:0] pid_in;
    logic        pid_done = 1'b0;
    logic [11:0] pid_duty = '0;
    logic [11:0] duty_out;
    logic        busy;
    logic [7:0]  overrun_cnt;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    pid_loop_sequencer #(
        .DATA_W    (16),
        .DUTY_W    (12),
        .DUTY_RESET(12'hFFF),
        .TIMEOUT   (16'd100)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .pid_tick    (pid_tick),
        .pwm_tick    (pwm_tick),
        .sample_req  (sample_req),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .pid_start   (pid_start),
        .pid_in      (pid_in),
        .pid_done    (pid_done),
        .pid_duty    (pid_duty),
        .duty_out    (duty_out),
        .busy        (busy),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk_in = ~clk_in;

    // One clock: inputs set before the call are sampled at this edge,
    // outputs are read 1 time unit after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        if (duty_out !== 12'hFFF) begin failures++; $display("FAIL reset_duty got=%h exp=fff", duty_out); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (overrun_cnt !== 8'd0) begin failures++; $display("FAIL reset_overrun got=%0d exp=0", overrun_cnt); end
        checks++;
        if (sample_req !== 1'b0 || pid_start !== 1'b0 || pid_in !== 16'h0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_misc got req=%b start=%b in=%h terr=%b exp 0/0/0000/0", sample_req, pid_start, pid_in, timeout_err);
        end
        checks++;
    endtask

    task automatic test_nominal();
        pid_tick = 1'b1; step(); pid_tick = 1'b0;
        if (sample_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL nom_req got req=%b busy=%b exp 1/1", sample_req, busy); end
        checks++;
        step();
        if (sample_req !== 1'b0) begin failures++; $display("FAIL nom_req_pulse got=%b exp=0", sample_req); end
        checks++;
        step();
        sample_valid = 1'b1; sample_data = 16'h1234; step(); sample_valid = 1'b0; sample_data = 16'hBEEF;
        if (pid_in !== 16'h1234 || pid_start !== 1'b1) begin failures++; $display("FAIL nom_pid_in got in=%h start=%b exp 1234/1", pid_in, pid_start); end
        checks++;
        step();
        if (pid_start !== 1'b0 || pid_in !== 16'h1234) begin failures++; $display("FAIL nom_start_pulse got start=%b in=%h exp 0/1234", pid_start, pid_in); end
        checks++;
        pid_done = 1'b1; pid_duty = 12'h400; step(); pid_done = 1'b0; pid_duty = 12'h0;
        for (int i = 0; i < 9; i++) step();
        if (duty_out !== 12'hFFF || busy !== 1'b1) begin failures++; $display("FAIL nom_hold got duty=%h busy=%b exp fff/1", duty_out, busy); end
        checks++;
        pwm_tick = 1'b1; step(); pwm_tick = 1'b0;
        if (duty_out !== 12'h400 || busy !== 1'b0) begin failures++; $display("FAIL nom_commit got duty=%h busy=%b exp 400/0", duty_out, busy); end
        checks++;
    endtask

    task automatic test_min_iteration();
        pid_tick = 1'b1; step(); pid_tick = 1'b0;
        sample_valid = 1'b1; sample_data = 16'h0055; step(); sample_valid = 1'b0;
        pid_done = 1'b1; pid_duty = 12'h123; step(); pid_done = 1'b0;
        pwm_tick = 1'b1; step(); pwm_tick = 1'b0;
        if (duty_out !== 12'h123 || busy !== 1'b0 || pid_in !== 16'h0055) begin
            failures++; $display("FAIL min_iter got duty=%h busy=%b in=%h exp 123/0/0055", duty_out, busy, pid_in);
        end
        checks++;
        if (overrun_cnt !== 8'd0) begin failures++; $display("FAIL min_iter_overrun got=%0d exp=0", overrun_cnt); end
        checks++;
    endtask

    task automatic test_ignored_strobes();
        sample_valid = 1'b1; sample_data = 16'hDEAD;
        pid_done = 1'b1; pid_duty = 12'h999; pwm_tick = 1'b1;
        step(); step();
        sample_valid = 1'b0; pid_done = 1'b0; pwm_tick = 1'b0;
        if (pid_in !== 16'h0055 || duty_out !== 12'h123 || busy !== 1'b0 || pid_start !== 1'b0) begin
            failures++; $display("FAIL idle_ignore got in=%h duty=%h busy=%b start=%b exp 0055/123/0/0", pid_in, duty_out, busy, pid_start);
        end
        checks++;
    endtask

    task automatic test_boundary();
        pid_tick = 1'b1; step(); pid_tick = 1'b0;
        sample_valid = 1'b1; sample_data = 16'h0A0A; step(); sample_valid = 1'b0;
        pid_done = 1'b1; pid_duty = 12'h7AB; pwm_tick = 1'b1; step();
        pid_done = 1'b0; pwm_tick = 1'b0;
        if (duty_out !== 12'h123 || busy !== 1'b1) begin failures++; $display("FAIL bnd_same_cycle got duty=%h busy=%b exp 123/1", duty_out, busy); end
        checks++;
        step(); step(); step();
        if (duty_out !== 12'h123) begin failures++; $display("FAIL bnd_wait got=%h exp=123", duty_out); end
        checks++;
        pwm_tick = 1'b1; step(); pwm_tick = 1'b0;
        if (duty_out !== 12'h7AB || busy !== 1'b0) begin failures++; $display("FAIL bnd_commit got duty=%h busy=%b exp 7ab/0", duty_out, busy); end
        checks++;
    endtask

    task automatic test_overrun();
        int n;
        logic [7:0] exp_cnt;
`ifdef SEQ_TIMEOUT_EN
        n = 60;
        exp_cnt = 8'd60;
`else
        n = 300;
        exp_cnt = 8'd255;
`endif
        pid_tick = 1'b1; step(); pid_tick = 1'b0;
        sample_valid = 1'b1; sample_data = 16'h0001; step(); sample_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            pid_tick = 1'b1; step();
        end
        pid_tick = 1'b0;
        if (overrun_cnt !== exp_cnt || busy !== 1'b1) begin failures++; $display("FAIL ovr_sat got cnt=%0d busy=%b exp %0d/1", overrun_cnt, busy, exp_cnt); end
        checks++;
        err_clr = 1'b1; pid_tick = 1'b1; step(); err_clr = 1'b0; pid_tick = 1'b0;
        if (overrun_cnt !== 8'd1) begin failures++; $display("FAIL ovr_clr_tick got=%0d exp=1", overrun_cnt); end
        checks++;
        err_clr = 1'b1; step(); err_clr = 1'b0;
        if (overrun_cnt !== 8'd0) begin failures++; $display("FAIL ovr_clr got=%0d exp=0", overrun_cnt); end
        checks++;
        pid_done = 1'b1; pid_duty = 12'h321; step(); pid_done = 1'b0;
        // tick coinciding with the commit tick is still an overrun
        pwm_tick = 1'b1; pid_tick = 1'b1; step(); pwm_tick = 1'b0; pid_tick = 1'b0;
        if (overrun_cnt !== 8'd1 || duty_out !== 12'h321 || busy !== 1'b0) begin
            failures++; $display("FAIL ovr_commit_tick got cnt=%0d duty=%h busy=%b exp 1/321/0", overrun_cnt, duty_out, busy);
        end
        checks++;
        step();
        if (sample_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ovr_dropped got req=%b busy=%b exp 0/0", sample_req, busy); end
        checks++;
        err_clr = 1'b1; step(); err_clr = 1'b0;
    endtask

    task automatic test_timeout();
        pid_tick = 1'b1; step(); pid_tick = 1'b0;
        for (int i = 0; i < 99; i++) step();
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_before got busy=%b terr=%b exp 1/0", busy, timeout_err); end
        checks++;
        step();
`ifdef SEQ_TIMEOUT_EN
        if (timeout_err !== 1'b1 || busy !== 1'b0 || duty_out !== 12'h321) begin
            failures++; $display("FAIL to_expire got terr=%b busy=%b duty=%h exp 1/0/321", timeout_err, busy, duty_out);
        end
        checks++;
        err_clr = 1'b1; step(); err_clr = 1'b0;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clr got=%b exp=0", timeout_err); end
        checks++;
`else
        for (int i = 0; i < 50; i++) step();
        if (timeout_err !== 1'b0 || busy !== 1'b1 || duty_out !== 12'h321) begin
            failures++; $display("FAIL to_wait got terr=%b busy=%b duty=%h exp 0/1/321", timeout_err, busy, duty_out);
        end
        checks++;
        sample_valid = 1'b1; sample_data = 16'h00AA; step(); sample_valid = 1'b0;
        pid_done = 1'b1; pid_duty = 12'h0F0; step(); pid_done = 1'b0;
        pwm_tick = 1'b1; step(); pwm_tick = 1'b0;
        if (duty_out !== 12'h0F0 || busy !== 1'b0) begin failures++; $display("FAIL to_resume got duty=%h busy=%b exp 0f0/0", duty_out, busy); end
        checks++;
`endif
    endtask

    task automatic test_mid_reset();
        pid_tick = 1'b1; step(); pid_tick = 1'b0;
        sample_valid = 1'b1; sample_data = 16'h0123; step(); sample_valid = 1'b0;
        pid_done = 1'b1; pid_duty = 12'h123; step(); pid_done = 1'b0;
        rst_n = 1'b0;
        #1;
        if (duty_out !== 12'hFFF || busy !== 1'b0 || pid_in !== 16'h0) begin
            failures++; $display("FAIL rst_async got duty=%h busy=%b in=%h exp fff/0/0000", duty_out, busy, pid_in);
        end
        checks++;
        step();
        rst_n = 1'b1;
        pwm_tick = 1'b1; step(); pwm_tick = 1'b0;
        if (duty_out !== 12'hFFF || busy !== 1'b0) begin failures++; $display("FAIL rst_discard got duty=%h busy=%b exp fff/0", duty_out, busy); end
        checks++;
        pid_tick = 1'b1; step(); pid_tick = 1'b0;
        if (sample_req !== 1'b1) begin failures++; $display("FAIL rst_idle got req=%b exp=1", sample_req); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_min_iteration();
        test_ignored_strobes();
        test_boundary();
        test_overrun();
        test_timeout();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
